// File: rtl/le_pkg.sv
// Shared types and configuration-field layout for the logic-element cluster.
// Each LE field is LUT bits first, then MODE, INIT and SRST_EN.
package le_pkg;

    typedef enum logic [1:0] {
        UNCONF,
        SHIFTING,
        CONFIGURED,
        ERROR
    } cfg_state_t;

    function automatic int le_cfg_w(input int k);
        return (1 << k) + 3;
    endfunction

    function automatic int MODE_OFS(input int k);
        return (1 << k);
    endfunction

    function automatic int INIT_OFS(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int SRST_OFS(input int k);
        return (1 << k) + 2;
    endfunction

endpackage

// File: rtl/le_cell.sv
// One logic element: a LUT_K-input LUT with an optional user flip-flop.
// The flip-flop takes INIT on load_init, otherwise updates only while active.
module le_cell
    import le_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [le_cfg_w(LUT_K)-1:0]   cfg,
    input  logic [LUT_K-1:0]             sel,
    input  logic                         le_en,
    input  logic                         le_srst,
    input  logic                         load_init,
    input  logic                         active,
    output logic                         le_out
);

    localparam int LUT_BITS = 1 << LUT_K;

    logic [LUT_BITS-1:0] lut;
    logic                mode;
    logic                init_val;
    logic                srst_en;
    logic                lut_bit;
    logic                ff;

    assign lut      = cfg[LUT_BITS-1:0];
    assign mode     = cfg[MODE_OFS(LUT_K)];
    assign init_val = cfg[INIT_OFS(LUT_K)];
    assign srst_en  = cfg[SRST_OFS(LUT_K)];
    assign lut_bit  = lut[sel];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ff <= 1'b0;
        end else if (load_init) begin
            ff <= init_val;
        end else if (active) begin
            if (le_srst && srst_en) begin
                ff <= init_val;
            end else if (le_en) begin
                ff <= lut_bit;
            end
        end
    end

    assign le_out = active & (mode ? ff : lut_bit);

endmodule

// File: rtl/le_cluster.sv
// Cluster of NUM_LE logic elements configured through one serial shift chain,
// with a load-checking FSM that only releases the outputs after an exact-length load.
module le_cluster
    import le_pkg::*;
#(
    parameter int LUT_K  = 4,
    parameter int NUM_LE = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    en,
    input  logic                    config_en,
    input  logic                    config_data_in,
    output logic                    config_data_out,
    output logic                    config_done,
    output logic                    config_err,
    input  logic                    le_en,
    input  logic                    le_srst,
    input  logic [NUM_LE*LUT_K-1:0] select,
    output logic [NUM_LE-1:0]       le_out
);

    localparam int LE_CFG_W = le_cfg_w(LUT_K);
    localparam int CFG_BITS = NUM_LE * LE_CFG_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] chain;
    logic [CNT_W-1:0]    count;
    cfg_state_t          state;
    logic                shift_en;
    logic                load_init;
    logic                cells_active;
    logic                out_en;
    logic [NUM_LE-1:0]   cell_out;

    assign shift_en     = en && config_en;
    assign load_init    = (state == SHIFTING) && !config_en && (count == CNT_FULL);
    assign cells_active = (state == CONFIGURED);
    // A new load request blanks the outputs immediately, before the state leaves CONFIGURED.
    assign out_en       = cells_active && !shift_en;

    // NOTE: the chain is configuration state, so it is reset like any control register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '0;
        end else if (shift_en) begin
            chain <= {chain[CFG_BITS-2:0], config_data_in};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= UNCONF;
            count       <= '0;
            config_done <= 1'b0;
            config_err  <= 1'b0;
        end else begin
            case (state)
                SHIFTING: begin
                    if (!config_en) begin
                        if (count == CNT_FULL) begin
                            state       <= CONFIGURED;
                            config_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            config_err <= 1'b1;
                        end
                    end else if (en && (count != CNT_MAX)) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    if (shift_en) begin
                        state       <= SHIFTING;
                        count       <= CNT_W'(1);
                        config_done <= 1'b0;
                        config_err  <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LE; i++) begin : g_le
        le_cell #(
            .LUT_K(LUT_K)
        ) u_cell (
            .clk      (clk),
            .nrst     (nrst),
            .cfg      (chain[i*LE_CFG_W +: LE_CFG_W]),
            .sel      (select[i*LUT_K +: LUT_K]),
            .le_en    (le_en),
            .le_srst  (le_srst),
            .load_init(load_init),
            .active   (cells_active),
            .le_out   (cell_out[i])
        );
    end

    assign le_out          = cell_out & {NUM_LE{out_en}};
    assign config_data_out = chain[CFG_BITS-1];

endmodule

// File: tb/tb_le_cluster.sv
// Self-checking bench for le_cluster (LUT_K=4, NUM_LE=2): directed scenarios
// plus randomized traffic, all checked against a field-level behavioural model.
module tb_le_cluster;

    localparam int LUT_K    = 4;
    localparam int NUM_LE   = 2;
    localparam int LE_W     = 19;
    localparam int CFG_BITS = 38;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic       config_en;
    logic       config_data_in;
    logic       config_data_out;
    logic       config_done;
    logic       config_err;
    logic       le_en;
    logic       le_srst;
    logic [7:0] select;
    logic [1:0] le_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    le_cluster #(
        .LUT_K (LUT_K),
        .NUM_LE(NUM_LE)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .config_en      (config_en),
        .config_data_in (config_data_in),
        .config_data_out(config_data_out),
        .config_done    (config_done),
        .config_err     (config_err),
        .le_en          (le_en),
        .le_srst        (le_srst),
        .select         (select),
        .le_out         (le_out)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_chain[j] is chain bit j; bit 0 is the most recently shifted-in bit.
    bit m_chain [CFG_BITS];
    bit m_ff    [NUM_LE];
    bit m_loading, m_done, m_err;
    int m_count;

    function automatic bit fld(input int i, input int b);
        return m_chain[i*LE_W + b];
    endfunction

    function automatic bit lut_of(input int i);
        int s;
        s = (int'(select) >> (i*LUT_K)) & 15;
        return fld(i, s);
    endfunction

    function automatic logic [1:0] exp_le_out();
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LE; i++)
            if (m_done && !(en && config_en))
                r[i] = fld(i, 16) ? m_ff[i] : lut_of(i);
        return r;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int j = 0; j < CFG_BITS; j++) m_chain[j] <= 1'b0;
            for (int i = 0; i < NUM_LE; i++)   m_ff[i]    <= 1'b0;
            m_loading <= 1'b0;
            m_done    <= 1'b0;
            m_err     <= 1'b0;
            m_count   <= 0;
        end else begin
            if (m_done)
                for (int i = 0; i < NUM_LE; i++) begin
                    if (le_srst && fld(i, 18)) m_ff[i] <= fld(i, 17);
                    else if (le_en)            m_ff[i] <= lut_of(i);
                end
            if (m_loading && !config_en) begin
                m_loading <= 1'b0;
                if (m_count == CFG_BITS) begin
                    m_done <= 1'b1;
                    for (int i = 0; i < NUM_LE; i++) m_ff[i] <= fld(i, 17);
                end else begin
                    m_err <= 1'b1;
                end
            end else if (en && config_en) begin
                if (!m_loading) begin
                    m_loading <= 1'b1;
                    m_done    <= 1'b0;
                    m_err     <= 1'b0;
                    m_count   <= 1;
                end else if (m_count < CFG_BITS + 1) begin
                    m_count <= m_count + 1;
                end
                m_chain[0] <= config_data_in;
                for (int j = 1; j < CFG_BITS; j++) m_chain[j] <= m_chain[j-1];
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("le_out",          le_out,          exp_le_out());
        check("config_done",     config_done,     m_done);
        check("config_err",      config_err,      m_err);
        check("config_data_out", config_data_out, m_chain[CFG_BITS-1]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input bit b);
        config_en      = 1'b1;
        en             = 1'b1;
        config_data_in = b;
        tick();
    endtask

    // Shifts n bits (MSB of v first), optionally with random or fixed en=0 gaps.
    task automatic load(input logic [37:0] v, input int n, input bit gaps,
                        input int gap_at, input int gap_len);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                config_en = 1'b1;
                en        = 1'b0;
                repeat (gap_len) tick();
            end
            if (gaps && $urandom_range(3) == 0) begin
                config_en = 1'b1;
                en        = 1'b0;
                tick();
            end
            if (k < CFG_BITS) shift_bit(v[37-k]);
            else              shift_bit(1'($urandom_range(1)));
        end
        config_en      = 1'b0;
        en             = 1'($urandom_range(1));
        config_data_in = 1'b0;
        tick();
        en = 1'b0;
    endtask

    logic [37:0] cfg_a;
    logic [37:0] pat;
    logic [37:0] rnd;

    initial begin
        nrst = 1'b0; en = 1'b0; config_en = 1'b0; config_data_in = 1'b0;
        le_en = 1'b0; le_srst = 1'b0; select = '0;
        #12;
        check("reset le_out", le_out, 8'h0);
        check("reset done", config_done, 8'h0);
        check("reset err", config_err, 8'h0);
        check("reset dout", config_data_out, 8'h0);
        tick();
        nrst = 1'b1;

        // Exact load: LE1 = XOR4 registered, INIT=1, SRST_EN=1; LE0 = AND4 combinational.
        cfg_a = {3'b111, 16'h6996, 3'b000, 16'h8000};
        load(cfg_a, 38, 1'b0, -1, 0);
        select = 8'hFF;
        #1;
        check("exact done", config_done, 8'h1);
        check("exact err", config_err, 8'h0);
        check("and4 all ones", le_out[0], 8'h1);
        check("init before le_en", le_out[1], 8'h1);
        select = 8'h0E;
        #1;
        check("and4 one zero", le_out[0], 8'h0);

        // Registered path.
        select = 8'h10; le_en = 1'b1; tick(); le_en = 1'b0;
        check("reg xor 0001", le_out[1], 8'h1);
        select = 8'h30; le_en = 1'b1; tick(); le_en = 1'b0;
        check("reg xor 0011", le_out[1], 8'h0);
        select = 8'h10; tick();
        check("reg hold no le_en", le_out[1], 8'h0);
        select = 8'h30; le_srst = 1'b1; le_en = 1'b1; tick();
        le_srst = 1'b0; le_en = 1'b0;
        check("srst beats le_en", le_out[1], 8'h1);

        // Requesting a load in CONFIGURED blanks outputs in the same cycle.
        select = 8'hFF; config_en = 1'b1; en = 1'b1;
        #1;
        check("reconfig blank", le_out, 8'h0);
        config_en = 1'b0; en = 1'b0;
        #1;
        check("reconfig unblank", le_out, 8'h3);

        // Short and over loads, then recovery.
        rnd = 38'({$urandom(), $urandom()});
        load(rnd, 37, 1'b0, -1, 0);
        check("short err", config_err, 8'h1);
        check("short le_out", le_out, 8'h0);
        load(rnd, 39, 1'b1, -1, 0);
        check("over err", config_err, 8'h1);
        check("over done", config_done, 8'h0);
        load(cfg_a, 38, 1'b1, -1, 0);
        check("recover done", config_done, 8'h1);
        check("recover err", config_err, 8'h0);

        // en gating: 5 stalled cycles mid-load.
        load(cfg_a, 38, 1'b0, 10, 5);
        check("gated done", config_done, 8'h1);
        check("gated le_out", le_out, 8'h3);

        // Daisy chain: the first 38 bits reappear at config_data_out from shift 39.
        pat = 38'({$urandom(), $urandom()});
        for (int k = 0; k < 76; k++) begin
            if (k < CFG_BITS) shift_bit(pat[37-k]);
            else              shift_bit(1'($urandom_range(1)));
            if (k + 1 >= CFG_BITS && k + 1 < 76)
                check("daisy bit", config_data_out, pat[37-(k+1-CFG_BITS)]);
        end
        config_en = 1'b0; en = 1'b0; tick();
        check("daisy over err", config_err, 8'h1);

        // Reset mid-load.
        load(cfg_a, 38, 1'b0, -1, 0);
        for (int k = 0; k < 20; k++) shift_bit(cfg_a[37-k]);
        nrst = 1'b0;
        #1;
        check("midreset le_out", le_out, 8'h0);
        check("midreset done", config_done, 8'h0);
        check("midreset err", config_err, 8'h0);
        check("midreset dout", config_data_out, 8'h0);
        config_en = 1'b0; en = 1'b0;
        tick();
        nrst = 1'b1;
        load(cfg_a, 38, 1'b0, -1, 0);
        check("post-reset done", config_done, 8'h1);

        // Randomized traffic against the model.
        for (int r = 0; r < 8; r++) begin
            rnd = 38'({$urandom(), $urandom()});
            load(rnd, ($urandom_range(7) == 0) ? 36 + $urandom_range(4) : 38, 1'b1, -1, 0);
            for (int c = 0; c < 40; c++) begin
                select  = 8'($urandom());
                le_en   = 1'($urandom_range(1));
                le_srst = ($urandom_range(7) == 0);
                if ($urandom_range(31) == 0) begin
                    config_en = 1'b1; en = 1'b1;
                end else begin
                    config_en = 1'b0; en = 1'($urandom_range(1));
                end
                config_data_in = 1'($urandom_range(1));
                tick();
            end
            config_en = 1'b0; en = 1'b0; le_en = 1'b0; le_srst = 1'b0;
            tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
